// File: rtl/spring_step_sequencer.sv
// Frame-level substep scheduler for the spring-force engine: starts each substep,
// buffers the node force stream with gravity applied, and feeds the integrator.
module spring_step_sequencer #(
    parameter int NUM_NODES       = 8,
    parameter int FORCE_SIZE      = 32,
    parameter int STEPS_PER_FRAME = 4,
    parameter int TIMEOUT_CYCLES  = 4096
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic                             frame_tick_in,
    input  logic                             enable_in,
    input  logic signed [FORCE_SIZE-1:0]     gravity_in,
    output logic                             springs_start,
    input  logic signed [FORCE_SIZE-1:0]     springs_force_x,
    input  logic signed [FORCE_SIZE-1:0]     springs_force_y,
    input  logic                             springs_force_valid,
    input  logic                             springs_done,
    output logic                             int_valid,
    input  logic                             int_ready,
    output logic [$clog2(NUM_NODES)-1:0]     int_node,
    output logic signed [FORCE_SIZE-1:0]     int_force_x,
    output logic signed [FORCE_SIZE-1:0]     int_force_y,
    output logic                             busy,
    output logic [$clog2(STEPS_PER_FRAME):0] substep,
    output logic                             frame_done,
    output logic                             err_timeout,
    output logic                             err_count,
    output logic [7:0]                       overrun_count
);

    localparam int NODE_W = $clog2(NUM_NODES);
    localparam int IDX_W  = $clog2(NUM_NODES + 1);
    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SUB_W  = $clog2(STEPS_PER_FRAME) + 1;

    localparam logic [IDX_W-1:0]  IDX_FULL  = IDX_W'(NUM_NODES);
    localparam logic [NODE_W-1:0] LAST_NODE = NODE_W'(NUM_NODES - 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(STEPS_PER_FRAME - 1);

    localparam logic signed [FORCE_SIZE-1:0] F_MAX = {1'b0, {(FORCE_SIZE-1){1'b1}}};
    localparam logic signed [FORCE_SIZE-1:0] F_MIN = {1'b1, {(FORCE_SIZE-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, COLLECT, INTEGRATE} state_t;

    state_t                       state;
    logic [IDX_W-1:0]             wr_idx;
    logic [TCNT_W-1:0]            tcnt;
    logic                         overflow;
    logic signed [FORCE_SIZE-1:0] fbuf_x [NUM_NODES];
    logic signed [FORCE_SIZE-1:0] fbuf_y [NUM_NODES];

    logic signed [FORCE_SIZE:0]   sum_y;
    logic signed [FORCE_SIZE-1:0] sat_y;
    logic                         write_en;
    logic                         beat_over;
    logic [IDX_W-1:0]             count_next;
    logic                         stream_ok;
    logic signed [FORCE_SIZE-1:0] first_x;
    logic signed [FORCE_SIZE-1:0] first_y;
    logic [NODE_W-1:0]            next_node;

    assign busy = (state != IDLE);

    // The final beat may coincide with springs_done, so the count check and the
    // first integrator word both look through the write happening this cycle.
    always_comb begin
        sum_y = {springs_force_y[FORCE_SIZE-1], springs_force_y}
              + {gravity_in[FORCE_SIZE-1], gravity_in};
        if (sum_y[FORCE_SIZE] != sum_y[FORCE_SIZE-1])
            sat_y = sum_y[FORCE_SIZE] ? F_MIN : F_MAX;
        else
            sat_y = sum_y[FORCE_SIZE-1:0];
        write_en   = (state == COLLECT) && springs_force_valid && (wr_idx != IDX_FULL);
        beat_over  = (state == COLLECT) && springs_force_valid && (wr_idx == IDX_FULL);
        count_next = wr_idx + IDX_W'(write_en);
        stream_ok  = !overflow && !beat_over && (count_next == IDX_FULL);
        first_x    = (write_en && wr_idx == '0) ? springs_force_x : fbuf_x[0];
        first_y    = (write_en && wr_idx == '0) ? sat_y : fbuf_y[0];
        next_node  = int_node + NODE_W'(1);
    end

    always_ff @(posedge clk_in) begin
        if (write_en) begin
            fbuf_x[wr_idx[NODE_W-1:0]] <= springs_force_x;
            fbuf_y[wr_idx[NODE_W-1:0]] <= sat_y;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state         <= IDLE;
            springs_start <= 1'b0;
            int_valid     <= 1'b0;
            int_node      <= '0;
            int_force_x   <= '0;
            int_force_y   <= '0;
            substep       <= '0;
            frame_done    <= 1'b0;
            err_timeout   <= 1'b0;
            err_count     <= 1'b0;
            overrun_count <= '0;
            wr_idx        <= '0;
            tcnt          <= '0;
            overflow      <= 1'b0;
        end else begin
            springs_start <= 1'b0;
            frame_done    <= 1'b0;
            if (frame_tick_in && enable_in && state != IDLE && overrun_count != 8'hFF)
                overrun_count <= overrun_count + 8'd1;

            case (state)
                IDLE: begin
                    if (frame_tick_in && enable_in) begin
                        state         <= COLLECT;
                        springs_start <= 1'b1;
                        substep       <= '0;
                        wr_idx        <= '0;
                        tcnt          <= '0;
                        overflow      <= 1'b0;
                    end
                end
                COLLECT: begin
                    tcnt <= tcnt + TCNT_W'(1);
                    if (write_en)
                        wr_idx <= wr_idx + IDX_W'(1);
                    if (beat_over) begin
                        err_count <= 1'b1;
                        overflow  <= 1'b1;
                    end
                    if (springs_done) begin
                        if (stream_ok) begin
                            state       <= INTEGRATE;
                            int_valid   <= 1'b1;
                            int_node    <= '0;
                            int_force_x <= first_x;
                            int_force_y <= first_y;
                        end else begin
                            err_count <= 1'b1;
                            state     <= IDLE;
                        end
                    end else if (tcnt == TCNT_LAST) begin
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                    end
                end
                INTEGRATE: begin
                    if (int_valid && int_ready) begin
                        if (int_node == LAST_NODE) begin
                            int_valid <= 1'b0;
                            if (substep < SUB_LAST) begin
                                substep       <= substep + SUB_W'(1);
                                state         <= COLLECT;
                                springs_start <= 1'b1;
                                wr_idx        <= '0;
                                tcnt          <= '0;
                                overflow      <= 1'b0;
                            end else begin
                                frame_done <= 1'b1;
                                state      <= IDLE;
                            end
                        end else begin
                            int_node    <= next_node;
                            int_force_x <= fbuf_x[next_node];
                            int_force_y <= fbuf_y[next_node];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spring_step_sequencer.sv
// Directed bench for spring_step_sequencer: behavioural engine and integrator
// drive the DUT on the falling edge and check every transfer against hand values.
module tb_spring_step_sequencer;

    localparam int NN = 8;

    logic               clk_in = 1'b0;
    logic               rst_in;
    logic               frame_tick_in;
    logic               enable_in;
    logic signed [31:0] gravity_in;
    logic               springs_start;
    logic signed [31:0] springs_force_x;
    logic signed [31:0] springs_force_y;
    logic               springs_force_valid;
    logic               springs_done;
    logic               int_valid;
    logic               int_ready;
    logic [2:0]         int_node;
    logic signed [31:0] int_force_x;
    logic signed [31:0] int_force_y;
    logic               busy;
    logic [2:0]         substep;
    logic               frame_done;
    logic               err_timeout;
    logic               err_count;
    logic [7:0]         overrun_count;

    int          vectors = 0;
    int          miscompares = 0;
    int          eng_beats = 8;
    bit          eng_done_en = 1'b1;
    logic [31:0] eng_fy = 32'd100;
    logic [31:0] exp_y = 32'd90;
    int          ready_mode = 0;
    int          eng_k = 0;
    int          eng_i = 0;
    int          eng_left = 0;
    int          mon_node = 0;
    bit          prev_stall = 1'b0;
    bit          prev_done_good = 1'b0;
    bit          prev_last = 1'b0;
    logic [2:0]  held_node;
    logic [31:0] held_x;
    logic [31:0] held_y;
    int          n_starts = 0;
    int          n_frames = 0;
    int          n_xfers = 0;
    int          n_valid = 0;
    int          cyc;

    spring_step_sequencer #(
        .NUM_NODES(8),
        .FORCE_SIZE(32),
        .STEPS_PER_FRAME(4),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .frame_tick_in(frame_tick_in),
        .enable_in(enable_in),
        .gravity_in(gravity_in),
        .springs_start(springs_start),
        .springs_force_x(springs_force_x),
        .springs_force_y(springs_force_y),
        .springs_force_valid(springs_force_valid),
        .springs_done(springs_done),
        .int_valid(int_valid),
        .int_ready(int_ready),
        .int_node(int_node),
        .int_force_x(int_force_x),
        .int_force_y(int_force_y),
        .busy(busy),
        .substep(substep),
        .frame_done(frame_done),
        .err_timeout(err_timeout),
        .err_count(err_count),
        .overrun_count(overrun_count)
    );

    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Engine stream x = start_number*256 + node, so order and substep are both visible.
    always @(negedge clk_in) begin
        springs_force_valid = 1'b0;
        springs_done = 1'b0;
        if (rst_in) begin
            eng_left = 0;
            prev_stall = 1'b0;
            prev_done_good = 1'b0;
            prev_last = 1'b0;
            int_ready = 1'b1;
        end else begin
            if (prev_stall) begin
                checkOutput("stall_valid", 32'(int_valid), 32'd1);
                checkOutput("stall_node", 32'(int_node), 32'(held_node));
                checkOutput("stall_x", int_force_x, held_x);
                checkOutput("stall_y", int_force_y, held_y);
            end
            if (prev_done_good)
                checkOutput("valid_after_done", 32'(int_valid), 32'd1);
            if (prev_last) begin
                checkOutput("valid_drop", 32'(int_valid), 32'd0);
                checkOutput("next_after_last", 32'(springs_start | frame_done), 32'd1);
            end
            prev_stall = 1'b0;
            prev_done_good = 1'b0;
            prev_last = 1'b0;
            if (springs_start) begin
                n_starts++;
                eng_k++;
                eng_i = 0;
                eng_left = eng_beats;
                mon_node = 0;
            end
            if (frame_done) begin
                n_frames++;
                checkOutput("frame_done_busy", 32'(busy), 32'd0);
            end
            if (int_valid)
                n_valid++;
            if (eng_left > 0) begin
                springs_force_valid = 1'b1;
                springs_force_x = 32'(eng_k * 256 + eng_i);
                springs_force_y = eng_fy;
                eng_i++;
                eng_left--;
                if (eng_left == 0 && eng_done_en) begin
                    springs_done = 1'b1;
                    prev_done_good = (eng_beats == NN);
                end
            end
            case (ready_mode)
                0:       int_ready = 1'b1;
                1:       int_ready = ($urandom_range(0, 1) == 1);
                default: int_ready = 1'b0;
            endcase
            if (int_valid && int_ready) begin
                checkOutput("xfer_node", 32'(int_node), 32'(mon_node));
                checkOutput("xfer_x", int_force_x, 32'(eng_k * 256 + mon_node));
                checkOutput("xfer_y", int_force_y, exp_y);
                n_xfers++;
                prev_last = (mon_node == NN - 1);
                mon_node++;
            end else if (int_valid) begin
                prev_stall = 1'b1;
                held_node = int_node;
                held_x = int_force_x;
                held_y = int_force_y;
            end
        end
    end

    task automatic applyStimulus(input logic tick, input logic en);
        @(negedge clk_in);
        frame_tick_in = tick;
        enable_in = en;
        @(negedge clk_in);
        frame_tick_in = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk_in);
            n++;
        end
        if (busy)
            checkOutput("wait_idle_budget", 32'(busy), 32'd0);
        repeat (2) @(negedge clk_in);
    endtask

    task automatic clearCounts();
        n_starts = 0;
        n_frames = 0;
        n_xfers = 0;
        n_valid = 0;
    endtask

    task automatic doReset();
        @(negedge clk_in);
        rst_in = 1'b1;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic runNormalFrame(input string tag);
        clearCounts();
        applyStimulus(1'b1, 1'b1);
        checkOutput({tag, "_start"}, 32'(springs_start), 32'd1);
        checkOutput({tag, "_substep0"}, 32'(substep), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
        enable_in = 1'b0;
        waitIdle(2000);
        checkOutput({tag, "_starts"}, 32'(n_starts), 32'd4);
        checkOutput({tag, "_xfers"}, 32'(n_xfers), 32'd32);
        checkOutput({tag, "_frames"}, 32'(n_frames), 32'd1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_in = 1'b1;
        frame_tick_in = 1'b0;
        enable_in = 1'b0;
        gravity_in = -32'sd10;
        int_ready = 1'b1;
        springs_force_x = '0;
        springs_force_y = '0;
        springs_force_valid = 1'b0;
        springs_done = 1'b0;
        repeat (3) @(negedge clk_in);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_int_valid", 32'(int_valid), 32'd0);
        checkOutput("rst_start", 32'(springs_start), 32'd0);
        checkOutput("rst_errs", 32'({err_timeout, err_count}), 32'd0);
        checkOutput("rst_overrun", 32'(overrun_count), 32'd0);
        rst_in = 1'b0;
        @(negedge clk_in);

        applyStimulus(1'b1, 1'b0);
        checkOutput("tick_disabled_busy", 32'(busy), 32'd0);
        checkOutput("tick_disabled_start", 32'(springs_start), 32'd0);

        runNormalFrame("frame");
        checkOutput("frame_err_timeout", 32'(err_timeout), 32'd0);
        checkOutput("frame_err_count", 32'(err_count), 32'd0);
        checkOutput("frame_overrun", 32'(overrun_count), 32'd0);

        ready_mode = 1;
        runNormalFrame("stall");
        ready_mode = 0;

        eng_done_en = 1'b0;
        clearCounts();
        applyStimulus(1'b1, 1'b1);
        cyc = 0;
        while (!err_timeout && cyc < 200) begin
            @(negedge clk_in);
            cyc++;
        end
        checkOutput("timeout_cycles", 32'(cyc), 32'd64);
        checkOutput("timeout_busy", 32'(busy), 32'd0);
        checkOutput("timeout_no_valid", 32'(n_valid), 32'd0);
        eng_done_en = 1'b1;
        repeat (2) @(negedge clk_in);
        runNormalFrame("after_timeout");
        checkOutput("timeout_sticky", 32'(err_timeout), 32'd1);

        doReset();
        eng_beats = 7;
        clearCounts();
        applyStimulus(1'b1, 1'b1);
        waitIdle(200);
        checkOutput("short_err_count", 32'(err_count), 32'd1);
        checkOutput("short_no_valid", 32'(n_valid), 32'd0);
        checkOutput("short_no_frame", 32'(n_frames), 32'd0);
        checkOutput("short_starts", 32'(n_starts), 32'd1);
        checkOutput("short_no_timeout", 32'(err_timeout), 32'd0);

        doReset();
        eng_beats = 9;
        clearCounts();
        applyStimulus(1'b1, 1'b1);
        waitIdle(200);
        checkOutput("long_err_count", 32'(err_count), 32'd1);
        checkOutput("long_no_valid", 32'(n_valid), 32'd0);
        checkOutput("long_no_frame", 32'(n_frames), 32'd0);
        eng_beats = 8;

        doReset();
        gravity_in = 32'sh100;
        eng_fy = 32'h7FFF_FFF0;
        exp_y = 32'h7FFF_FFFF;
        runNormalFrame("sat_pos");
        gravity_in = -32'sh100;
        eng_fy = 32'h8000_0005;
        exp_y = 32'h8000_0000;
        runNormalFrame("sat_neg");
        gravity_in = -32'sd10;
        eng_fy = 32'd100;
        exp_y = 32'd90;

        doReset();
        clearCounts();
        ready_mode = 2;
        applyStimulus(1'b1, 1'b1);
        cyc = 0;
        while (!int_valid && cyc < 100) begin
            @(negedge clk_in);
            cyc++;
        end
        checkOutput("stuck_int_valid", 32'(int_valid), 32'd1);
        repeat (3) begin
            @(negedge clk_in);
            frame_tick_in = 1'b1;
            enable_in = 1'b0;
        end
        @(negedge clk_in);
        frame_tick_in = 1'b0;
        enable_in = 1'b1;
        @(negedge clk_in);
        checkOutput("overrun_disabled", 32'(overrun_count), 32'd0);
        repeat (10) begin
            @(negedge clk_in);
            frame_tick_in = 1'b1;
        end
        @(negedge clk_in);
        frame_tick_in = 1'b0;
        @(negedge clk_in);
        checkOutput("overrun_10", 32'(overrun_count), 32'd10);
        repeat (290) begin
            @(negedge clk_in);
            frame_tick_in = 1'b1;
        end
        @(negedge clk_in);
        frame_tick_in = 1'b0;
        @(negedge clk_in);
        checkOutput("overrun_sat", 32'(overrun_count), 32'd255);
        checkOutput("overrun_still_busy", 32'(busy), 32'd1);

        @(posedge clk_in);
        #2;
        rst_in = 1'b1;
        #1;
        checkOutput("async_busy", 32'(busy), 32'd0);
        checkOutput("async_int_valid", 32'(int_valid), 32'd0);
        checkOutput("async_force_x", int_force_x, 32'd0);
        checkOutput("async_force_y", int_force_y, 32'd0);
        checkOutput("async_overrun", 32'(overrun_count), 32'd0);
        checkOutput("async_flags", 32'({springs_start, frame_done, err_timeout, err_count}), 32'd0);
        checkOutput("async_node_sub", 32'({int_node, substep}), 32'd0);
        ready_mode = 0;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        clearCounts();
        repeat (30) @(negedge clk_in);
        checkOutput("post_reset_no_frame", 32'(n_frames), 32'd0);
        checkOutput("post_reset_no_start", 32'(n_starts), 32'd0);
        checkOutput("post_reset_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spring_step_sequencer.md
# spring_step_sequencer

Frame-level scheduler for the spring-force engine: on each frame tick it runs a configurable number of physics substeps. For each substep it:
- pulses the `springs` engine start;
- captures the per-node force stream and adds gravity to the y component;
- hands each node's total force to the downstream integrator over a valid/ready handshake.

It sits between the frame timing logic and the `springs`/integrator pair. It guarantees the engine is never restarted while busy, and it detects hung or malformed force streams.

## Interface
Parameters:
- NUM_NODES, 8, nodes per substep; force stream length
- FORCE_SIZE, 32, signed force width
- STEPS_PER_FRAME, 4, substeps per frame tick (≥1)
- TIMEOUT_CYCLES, 4096, max cycles from start pulse to engine done

Ports:
- clk_in  input  1  clock
- rst_in  input  1  reset; asynchronous, active-high
- frame_tick_in  input  1  single-cycle frame request
- enable_in  input  1  ticks ignored while low
- gravity_in  input  FORCE_SIZE signed  added to every node's y force
- springs_start  output  1  one-cycle pulse to the engine's input_valid
- springs_force_x, springs_force_y  input  FORCE_SIZE signed  streamed node force
- springs_force_valid  input  1  qualifies one node force, in node order 0..NUM_NODES-1
- springs_done  input  1  engine output_valid (end of stream)
- int_valid  output  1  integrator request valid
- int_ready  input  1  integrator accepts
- int_node  output  $clog2(NUM_NODES)  node index of request
- int_force_x, int_force_y  output  FORCE_SIZE signed  total force for node
- busy  output  1  high in any state but IDLE
- substep  output  $clog2(STEPS_PER_FRAME)+1  current substep index
- frame_done  output  1  one-cycle pulse after last substep's last transfer
- err_timeout, err_count  output  1  sticky error flags
- overrun_count  output  8  saturating count of dropped ticks

## Operation
- Reset values: every output is 0; state is IDLE; the force buffer is not reset.
- **IDLE**
  - A tick with enable_in=1 is accepted.
  - Next cycle: state is COLLECT, springs_start=1 for that cycle only, substep=0, timeout counter=0, write index=0.
- **COLLECT**
  - Each cycle with springs_force_valid=1 writes buf[idx] = {x, sat(y + gravity_in)} and increments idx.
  - Writes beyond NUM_NODES-1 are dropped and set err_count.
  - On springs_done:
    - if idx==NUM_NODES, go to INTEGRATE with read index 0;
    - otherwise set err_count and go to IDLE with no frame_done.
  - The timeout counter increments every COLLECT cycle. When it reaches TIMEOUT_CYCLES before springs_done, set err_timeout and go to IDLE.
- **INTEGRATE**
  - int_valid=1 while driving int_node=rd and int_force_x/int_force_y=buf[rd].
  - A transfer happens on int_valid && int_ready.
  - While int_valid && !int_ready, all int_* outputs are held stable.
  - After the transfer of node NUM_NODES-1, int_valid drops next cycle, and then:
    - if substep < STEPS_PER_FRAME-1: increment substep, re-enter COLLECT with springs_start pulse, clear counters;
    - else: pulse frame_done, return to IDLE.
- Ticks:
  - A tick while busy increments overrun_count (saturates at 255) and is otherwise ignored.
  - A tick with enable_in=0 is ignored and not counted.
  - Deasserting enable_in mid-frame does not abort the frame.
- Saturation: sat() clamps to [-2^(FORCE_SIZE-1), 2^(FORCE_SIZE-1)-1]. x passes unmodified.
- Sticky errors: err_* clear only on reset. Errors do not block later frames.
- springs_force_valid or springs_done outside COLLECT are ignored.

## Timing
- Tick at cycle T (IDLE) gives springs_start at T+1. Exactly one start pulse per substep.
- Force write: a stream beat at cycle C is visible in buf at C+1.
- springs_done and the final force beat may arrive in the same cycle. The beat is written first, and the count check includes it.
- INTEGRATE with int_ready tied high: one node per cycle, NUM_NODES cycles; first int_valid the cycle after springs_done.
- Between the last integrator transfer at cycle D:
  - next substep's springs_start at D+1;
  - or frame_done at D+1 with busy=0 at D+1.
- A tick arriving in the same cycle frame_done pulses is an overrun, because busy was high when it was sampled.
- Asynchronous reset mid-frame: outputs go to 0 immediately, state to IDLE, no frame_done.

## Test plan
- NUM_NODES=8, STEPS=4, gravity=-10, int_ready=1, engine model streams force_y=100 per node. One tick gives 4 start pulses, 32 transfers all with int_force_y=90, then a single frame_done; errors stay 0.
- int_ready toggling 1-0-0-1 pseudo-randomly: every stalled request holds int_node/int_force_* stable; all 8 nodes arrive in order 0..7 per substep.
- Engine model never asserts springs_done, TIMEOUT_CYCLES=64: err_timeout=1 at 64 cycles after start; busy=0; the next tick runs normally.
- Engine sends 7 beats then done: err_count=1, no int_valid, no frame_done. Engine sends 9 beats: err_count=1, frame aborted.
- force_y=0x7FFF_FFF0, gravity=+0x100: int_force_y=0x7FFF_FFFF. force_y=0x8000_0005, gravity=-0x100: int_force_y=0x8000_0000.
- 300 ticks while busy: overrun_count saturates at 255. Asserting rst_in mid-INTEGRATE: all outputs 0 in the same cycle, no frame_done afterwards.
